// File: rtl/alu_control_mdu_if.sv
// Execute-stage control bundle: decode inputs, MDU operands/handshake, decode and MDU results.
// mdu_state exposes the MDU FSM (0 IDLE, 1 MUL, 2 DIV, 3 DONE) for observation.
interface alu_control_mdu_if #(parameter int XLEN = 32);
    logic [1:0]      aluop_in;
    logic [6:0]      func7;
    logic [2:0]      func3;
    logic            valid_in;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [3:0]      aluop_out;
    logic            is_mdu;
    logic            in_ready;
    logic            mdu_busy;
    logic            mdu_valid;
    logic [XLEN-1:0] mdu_result;
    logic [1:0]      mdu_state;

    modport master (
        output aluop_in, func7, func3, valid_in, operand_a, operand_b,
        input  aluop_out, is_mdu, in_ready, mdu_busy, mdu_valid, mdu_result, mdu_state
    );

    modport slave (
        input  aluop_in, func7, func3, valid_in, operand_a, operand_b,
        output aluop_out, is_mdu, in_ready, mdu_busy, mdu_valid, mdu_result, mdu_state
    );
endinterface

// File: rtl/alu_control_mdu.sv
// RV32IM ALU-op decode plus iterative multiply/divide unit.
// Define MDU_FAST_MUL_EN to replace shift-add multiply with a single-cycle multiplier.
module alu_control_mdu #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_control_mdu_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    state_t state, state_next;

    logic [3:0]      base_op;
    logic [3:0]      aluop;
    logic            mdu_op;
    logic            accept;

    logic [CW-1:0]   cnt;
    logic [2:0]      op_f3;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            neg_q, neg_r, bypass;
    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN-1:0] div_rem, div_quo;
    logic [XLEN-1:0] result;

    always_comb begin
        base_op = OP_NOP;
        case (bus.func3)
            3'b000:  base_op = OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = OP_SLT;
            3'b011:  base_op = OP_SLTU;
            3'b100:  base_op = OP_XOR;
            3'b101:  base_op = OP_SRL;
            3'b110:  base_op = OP_OR;
            default: base_op = OP_AND;
        endcase
    end

    // R-type with func7=0100000 is only legal for sub and sra; everything else decodes to NOP.
    always_comb begin
        aluop  = OP_NOP;
        mdu_op = 1'b0;
        case (bus.aluop_in)
            2'b00: aluop = OP_ADD;
            2'b01: aluop = OP_SUB;
            2'b10: begin
                if (bus.func7 == 7'b0000000) begin
                    aluop = base_op;
                end else if (bus.func7 == 7'b0100000) begin
                    if (bus.func3 == 3'b000)      aluop = OP_SUB;
                    else if (bus.func3 == 3'b101) aluop = OP_SRA;
                end else if (bus.func7 == 7'b0000001) begin
                    mdu_op = 1'b1;
                end
            end
            default: aluop = (bus.func3 == 3'b101 && bus.func7[5]) ? OP_SRA : base_op;
        endcase
    end

    assign bus.aluop_out = aluop;
    assign bus.is_mdu    = mdu_op;

    // Handshake: an M-op is taken on a rising edge where valid_in, is_mdu and in_ready are all
    // high; valid_in at any other time is ignored. mdu_valid pulses once with mdu_result.
    assign accept = bus.valid_in && mdu_op && (state == IDLE);

    logic            sgn_a, sgn_b, a_neg, b_neg, boundary;
    logic [XLEN-1:0] a_mag, b_mag, special;

    always_comb begin
        sgn_a    = (bus.func3 == 3'b001) || (bus.func3 == 3'b010) ||
                   (bus.func3 == 3'b100) || (bus.func3 == 3'b110);
        sgn_b    = (bus.func3 == 3'b001) || (bus.func3 == 3'b100) || (bus.func3 == 3'b110);
        a_neg    = sgn_a && bus.operand_a[XLEN-1];
        b_neg    = sgn_b && bus.operand_b[XLEN-1];
        a_mag    = a_neg ? -bus.operand_a : bus.operand_a;
        b_mag    = b_neg ? -bus.operand_b : bus.operand_b;
        boundary = 1'b0;
        special  = '1;
        if (bus.func3[2]) begin
            if (bus.operand_b == '0) begin
                boundary = 1'b1;
                special  = bus.func3[1] ? bus.operand_a : '1;
            end else if (sgn_b && bus.operand_a == MIN_VAL && bus.operand_b == '1) begin
                boundary = 1'b1;
                special  = bus.func3[1] ? '0 : MIN_VAL;
            end
        end
    end

    logic [2*XLEN-1:0] mul_step, mul_signed;
    logic              mul_last;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem_step, div_quo_step, q_signed, r_signed, final_val;

`ifdef MDU_FAST_MUL_EN
    assign mul_step = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
    assign mul_last = 1'b1;
`else
    logic [XLEN-1:0] mul_addend;
    logic [XLEN:0]   mul_sum;
    // Multiplier sits in the low half and drains out as the product shifts in from the top.
    assign mul_addend = mul_acc[0] ? a_abs : {XLEN{1'b0}};
    assign mul_sum    = {1'b0, mul_acc[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    assign mul_step   = {mul_sum, mul_acc[XLEN-1:1]};
    assign mul_last   = (cnt == '0);
`endif

    always_comb begin
        div_shift    = {div_rem, div_quo[XLEN-1]};
        div_diff     = div_shift - {1'b0, b_abs};
        div_ge       = !div_diff[XLEN];
        div_rem_step = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_quo_step = {div_quo[XLEN-2:0], div_ge};
        mul_signed   = neg_q ? -mul_step : mul_step;
        q_signed     = neg_q ? -div_quo_step : div_quo_step;
        r_signed     = neg_r ? -div_rem_step : div_rem_step;
        case (op_f3)
            3'b000:                 final_val = mul_signed[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_val = mul_signed[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_val = q_signed;
            default:                final_val = r_signed;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Boundary divides spend one DIV cycle with the step suppressed, giving a two-cycle latency.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = bus.func3[2] ? DIV : MUL;
            MUL:  if (mul_last) state_next = DONE;
            DIV:  if (bypass || cnt == '0) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.mdu_busy  = (state != IDLE) || (bus.valid_in && mdu_op);
        bus.mdu_valid = (state == DONE);
        bus.mdu_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            op_f3   <= '0;
            a_abs   <= '0;
            b_abs   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            bypass  <= 1'b0;
            mul_acc <= '0;
            div_rem <= '0;
            div_quo <= '0;
            result  <= '0;
        end else if (accept) begin
            cnt     <= CW'(XLEN - 1);
            op_f3   <= bus.func3;
            a_abs   <= a_mag;
            b_abs   <= b_mag;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            bypass  <= boundary;
            mul_acc <= {{XLEN{1'b0}}, b_mag};
            div_rem <= '0;
            div_quo <= a_mag;
            if (boundary) result <= special;
        end else if (state == MUL) begin
            mul_acc <= mul_step;
            cnt     <= cnt - CW'(1);
            if (mul_last) result <= final_val;
        end else if (state == DIV && !bypass) begin
            div_rem <= div_rem_step;
            div_quo <= div_quo_step;
            cnt     <= cnt - CW'(1);
            if (cnt == '0) result <= final_val;
        end
    end

    assign bus.mdu_result = result;
endmodule

// File: tb/tb_alu_control_mdu.sv
// Bench for alu_control_mdu: decode sweep, directed MDU cases, reset abort, random stream
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_control_mdu;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_control_mdu_if #(.XLEN(XLEN)) bus ();
    alu_control_mdu #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [6:0] f7,
                                              input logic [2:0] f3);
        logic [3:0] tbl [8];
        tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
        if (op == 2'd0) return 4'b0010;
        if (op == 2'd1) return 4'b0110;
        if (op == 2'd3) return (f3 == 3'd5 && f7[5]) ? 4'b0111 : tbl[f3];
        if (f7 == 7'h00) return tbl[f3];
        if (f7 == 7'h20 && f3 == 3'd0) return 4'b0110;
        if (f7 == 7'h20 && f3 == 3'd5) return 4'b0111;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return MUL_LAT;
        if (b == 0) return 2;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == MIN && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    // Reference model: cycles left until the unit is idle again, plus the expected results.
    int          left = 0;
    bit          cur_div = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_hold = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left = 0;
            exp_q.delete();
            exp_hold = '0;
            cur_div = 1'b0;
        end else if (left > 0) begin
            left--;
        end else if (bus.valid_in && bus.aluop_in == 2'd2 && bus.func7 == 7'h01) begin
            exp_q.push_back(ref_mdu(bus.func3, bus.operand_a, bus.operand_b));
            left    = ref_lat(bus.func3, bus.operand_a, bus.operand_b);
            cur_div = bus.func3[2];
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("aluop_out", bus.aluop_out, ref_decode(bus.aluop_in, bus.func7, bus.func3));
            check("is_mdu", bus.is_mdu, bus.aluop_in == 2'd2 && bus.func7 == 7'h01);
            if (rst_n) begin
                check("in_ready", bus.in_ready, left == 0);
                check("mdu_busy", bus.mdu_busy, left != 0 ||
                      (bus.valid_in && bus.aluop_in == 2'd2 && bus.func7 == 7'h01));
                check("mdu_valid", bus.mdu_valid, left == 1);
                check("mdu_state", bus.mdu_state,
                      (left == 0) ? 2'd0 : (left == 1) ? 2'd3 : (cur_div ? 2'd2 : 2'd1));
                if (left == 1) begin
                    check("exp_q_depth", exp_q.size(), 1);
                    if (exp_q.size() > 0) exp_hold = exp_q.pop_front();
                    check("mdu_result", bus.mdu_result, exp_hold);
                end else if (left == 0) begin
                    check("mdu_result_hold", bus.mdu_result, exp_hold);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic v);
        bus.aluop_in  = op;
        bus.func7     = f7;
        bus.func3     = f3;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.valid_in  = v;
    endtask

    task automatic dec_lit(input string name, input logic [1:0] op, input logic [6:0] f7,
                           input logic [2:0] f3, input logic [3:0] code, input logic m);
        @(posedge clk); #1;
        drive(op, f7, f3, 32'd0, 32'd0, 1'b0);
        #1;
        check({name, "_op"}, bus.aluop_out, code);
        check({name, "_mdu"}, bus.is_mdu, m);
    endtask

    task automatic wait_ready();
        int guard = 0;
        @(posedge clk); #1;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("wait_ready", bus.in_ready, 1'b1);
    endtask

    task automatic mdu_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input bit intrude);
        int lat;
        wait_ready();
        drive(2'd2, 7'h01, f3, a, b, 1'b1);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        lat = 1;
        while (!bus.mdu_valid && lat < 60) begin
            if (intrude && lat == 5) drive(2'd2, 7'h01, f3 ^ 3'd1, a ^ 32'h55, b + 32'd3, 1'b1);
            else bus.valid_in = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        bus.valid_in = 1'b0;
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_res"}, bus.mdu_result, exp_res);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(2'd0, 7'd0, 3'd0, 32'd0, 32'd0, 1'b0);
        #12;
        check("rst_valid", bus.mdu_valid, 1'b0);
        check("rst_result", bus.mdu_result, 32'd0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_busy", bus.mdu_busy, 1'b0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        dec_lit("ldst",      2'd0, 7'h7F, 3'd7, 4'b0010, 1'b0);
        dec_lit("branch",    2'd1, 7'h00, 3'd0, 4'b0110, 1'b0);
        dec_lit("r_sub",     2'd2, 7'h20, 3'd0, 4'b0110, 1'b0);
        dec_lit("r_sra",     2'd2, 7'h20, 3'd5, 4'b0111, 1'b0);
        dec_lit("r_sltu",    2'd2, 7'h00, 3'd3, 4'b1001, 1'b0);
        dec_lit("r_bad_and", 2'd2, 7'h20, 3'd7, 4'b1111, 1'b0);
        dec_lit("r_bad_f7",  2'd2, 7'h40, 3'd0, 4'b1111, 1'b0);
        dec_lit("i_srai",    3'd3, 7'h20, 3'd5, 4'b0111, 1'b0);
        dec_lit("i_addi",    3'd3, 7'h20, 3'd0, 4'b0010, 1'b0);
        dec_lit("r_mul",     2'd2, 7'h01, 3'd0, 4'b1111, 1'b1);

        for (int op = 0; op < 4; op++)
            for (int f7 = 0; f7 < 128; f7++)
                for (int f3 = 0; f3 < 8; f3++) begin
                    @(posedge clk); #1;
                    drive(op[1:0], f7[6:0], f3[2:0], 32'd0, 32'd0, 1'b0);
                end

        mdu_op("mul",      3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b0);
        mdu_op("mulh",     3'd1, MIN,          MIN,           32'h4000_0000, MUL_LAT, 1'b0);
        mdu_op("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
        mdu_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT, 1'b0);
        mdu_op("div",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0);
        mdu_op("rem",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
        mdu_op("divu",     3'd5, 32'd100,      32'd7,         32'd14,        33, 1'b0);
        mdu_op("remu",     3'd7, 32'd100,      32'd7,         32'd2,         33, 1'b0);
        mdu_op("divu_z",   3'd5, 32'd5,        32'd0,         32'hFFFF_FFFF, 2, 1'b0);
        mdu_op("remu_z",   3'd7, 32'd5,        32'd0,         32'd5,         2, 1'b0);
        mdu_op("rem_z",    3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2, 1'b0);
        mdu_op("div_ovf",  3'd4, MIN,          32'hFFFF_FFFF, MIN,           2, 1'b0);
        mdu_op("rem_ovf",  3'd6, MIN,          32'hFFFF_FFFF, 32'd0,         2, 1'b0);
        mdu_op("divu_int", 3'd5, 32'd100,      32'd7,         32'd14,        33, 1'b1);
        mdu_op("mul_int",  3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b1);

        // Abort a divide partway through with reset, then run a fresh multiply.
        wait_ready();
        drive(2'd2, 7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", bus.mdu_valid, 1'b0);
        check("abort_result", bus.mdu_result, 32'd0);
        check("abort_busy", bus.mdu_busy, 1'b0);
        check("abort_in_ready", bus.in_ready, 1'b1);
        check("abort_state", bus.mdu_state, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mdu_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, MUL_LAT, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            drive(2'($urandom_range(0, 3)), 7'($urandom), 3'($urandom_range(0, 7)),
                  pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
            case ($urandom_range(0, 3))
                0: bus.func7 = 7'h00;
                1: bus.func7 = 7'h20;
                2: bus.func7 = 7'h01;
                default: ;
            endcase
            if ($urandom_range(0, 2) == 0) begin
                bus.aluop_in = 2'd2;
                bus.func7    = 7'h01;
            end
        end
        bus.valid_in = 1'b0;
        for (int i = 0; i < 40 && left != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
